// File: rtl/dcache_mem_requester.sv
// D-cache line-miss requester toward the memory controller: one outstanding
// miss, optional dirty-victim writeback, refill return, timeout/ack checks.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   miss_req/miss_addr    refill request from the cache (sampled in IDLE)
//   victim_dirty/_addr/_data  writeback carried with the miss
//   busy                  transaction in progress
//   fill_valid/_addr/_data    one-cycle refill return
//   err_timeout, err_wb_noack sticky error flags
//   reqD_cache, reqD_cache_write, reqAddrD_mem, reqAddrD_write_mem,
//   data_from_cache       request side toward the memory controller
//   data_to_cache, read_ready_for_dcache, written_data_ack
//                         response side from the memory controller
module dcache_mem_requester #(
    parameter int ADDR_W  = 26,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    output logic              busy,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              err_timeout,
    output logic              err_wb_noack,
    output logic              reqD_cache,
    output logic              reqD_cache_write,
    output logic [ADDR_W-1:0] reqAddrD_mem,
    output logic [ADDR_W-1:0] reqAddrD_write_mem,
    output logic [LINE_W-1:0] data_from_cache,
    input  logic [LINE_W-1:0] data_to_cache,
    input  logic              read_ready_for_dcache,
    input  logic              written_data_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              dirty_q;
    logic              wb_acked;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            cnt                <= '0;
            dirty_q            <= 1'b0;
            wb_acked           <= 1'b0;
            line_q             <= '0;
            busy               <= 1'b0;
            fill_valid         <= 1'b0;
            fill_addr          <= '0;
            fill_data          <= '0;
            err_timeout        <= 1'b0;
            err_wb_noack       <= 1'b0;
            reqD_cache         <= 1'b0;
            reqD_cache_write   <= 1'b0;
            reqAddrD_mem       <= '0;
            reqAddrD_write_mem <= '0;
            data_from_cache    <= '0;
        end else begin
            fill_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        reqD_cache         <= 1'b1;
                        reqAddrD_mem       <= miss_addr;
                        reqD_cache_write   <= victim_dirty;
                        // A clean miss presents an all-zero writeback bus.
                        reqAddrD_write_mem <= victim_dirty ? victim_addr : '0;
                        data_from_cache    <= victim_dirty ? victim_data : '0;
                        dirty_q            <= victim_dirty;
                        wb_acked           <= 1'b0;
                        cnt                <= '0;
                        busy               <= 1'b1;
                        state              <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (written_data_ack) begin
                        wb_acked         <= 1'b1;
                        reqD_cache_write <= 1'b0;
                    end
                    if (read_ready_for_dcache) begin
                        line_q           <= data_to_cache;
                        reqD_cache       <= 1'b0;
                        reqD_cache_write <= 1'b0;
                        // An ack arriving on the same edge still counts.
                        if (dirty_q && !wb_acked && !written_data_ack)
                            err_wb_noack <= 1'b1;
                        state <= S_FILL;
                    end else if (cnt == CNT_MAX) begin
                        err_timeout      <= 1'b1;
                        reqD_cache       <= 1'b0;
                        reqD_cache_write <= 1'b0;
                        state            <= S_GAP;
                    end
                end
                S_FILL: begin
                    fill_valid <= 1'b1;
                    fill_addr  <= reqAddrD_mem;
                    fill_data  <= line_q;
                    state      <= S_GAP;
                end
                S_GAP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_requester.sv
// Directed table-driven bench for dcache_mem_requester with hand-written
// sequences for timeout, back-to-back misses and mid-transaction reset.
module tb_dcache_mem_requester;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_req;
    logic [25:0]  miss_addr;
    logic         victim_dirty;
    logic [25:0]  victim_addr;
    logic [127:0] victim_data;
    logic         busy;
    logic         fill_valid;
    logic [25:0]  fill_addr;
    logic [127:0] fill_data;
    logic         err_timeout;
    logic         err_wb_noack;
    logic         reqD_cache;
    logic         reqD_cache_write;
    logic [25:0]  reqAddrD_mem;
    logic [25:0]  reqAddrD_write_mem;
    logic [127:0] data_from_cache;
    logic [127:0] data_to_cache;
    logic         read_ready_for_dcache;
    logic         written_data_ack;

    dcache_mem_requester dut (
        .clk                   (clk),
        .reset                 (reset),
        .miss_req              (miss_req),
        .miss_addr             (miss_addr),
        .victim_dirty          (victim_dirty),
        .victim_addr           (victim_addr),
        .victim_data           (victim_data),
        .busy                  (busy),
        .fill_valid            (fill_valid),
        .fill_addr             (fill_addr),
        .fill_data             (fill_data),
        .err_timeout           (err_timeout),
        .err_wb_noack          (err_wb_noack),
        .reqD_cache            (reqD_cache),
        .reqD_cache_write      (reqD_cache_write),
        .reqAddrD_mem          (reqAddrD_mem),
        .reqAddrD_write_mem    (reqAddrD_write_mem),
        .data_from_cache       (data_from_cache),
        .data_to_cache         (data_to_cache),
        .read_ready_for_dcache (read_ready_for_dcache),
        .written_data_ack      (written_data_ack)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] DA = 128'hDEAD0000_11112222_33334444_5555BEEF;
    localparam logic [127:0] DB = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DC = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] DD = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] VA = {4{32'h55555555}};

    typedef struct {
        logic         rst, mreq;
        logic [25:0]  addr;
        logic         vd;
        logic [25:0]  vaddr;
        logic [127:0] vdata;
        logic         rdy, ack;
        logic [127:0] din;
        logic         e_req, e_wr, e_busy, e_fv, e_eto, e_ewb;
        logic [25:0]  e_faddr, e_waddr;
        logic [127:0] e_fdata;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic mreq, input logic [25:0] addr,
                       input logic vd, input logic [25:0] vaddr, input logic [127:0] vdata,
                       input logic rdy, input logic ack, input logic [127:0] din,
                       input logic e_req, input logic e_wr, input logic e_busy,
                       input logic e_fv, input logic e_eto, input logic e_ewb,
                       input logic [25:0] e_faddr, input logic [25:0] e_waddr,
                       input logic [127:0] e_fdata);
        vec_t v;
        v.rst = rst; v.mreq = mreq; v.addr = addr; v.vd = vd;
        v.vaddr = vaddr; v.vdata = vdata; v.rdy = rdy; v.ack = ack; v.din = din;
        v.e_req = e_req; v.e_wr = e_wr; v.e_busy = e_busy; v.e_fv = e_fv;
        v.e_eto = e_eto; v.e_ewb = e_ewb; v.e_faddr = e_faddr;
        v.e_waddr = e_waddr; v.e_fdata = e_fdata;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_req = 0; miss_addr = '0; victim_dirty = 0; victim_addr = '0;
        victim_data = '0; read_ready_for_dcache = 0; written_data_ack = 0;
        data_to_cache = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();

        // rst mreq addr vd vaddr vdata rdy ack din | req wr busy fv eto ewb faddr waddr fdata
        add(1,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h1A0,0,26'h0,0,0,0,0,      1,0,1,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h1A0,0,26'h0,0,0,0,0,      1,0,1,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h1A0,0,26'h0,0,0,0,0,      1,0,1,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h1A0,0,26'h0,0,1,0,DA,     0,0,1,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h1A0,0,26'h0,0,0,0,0,      0,0,1,1,0,0,26'h1A0,26'h0,DA);
        add(0,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,0,26'h1A0,26'h0,DA);
        add(0,0,26'h0,0,26'h0,0,1,1,DB,       0,0,0,0,0,0,26'h1A0,26'h0,DA);
        add(0,1,26'h40,1,26'h80,VA,0,0,0,     1,1,1,0,0,0,26'h1A0,26'h80,DA);
        add(0,1,26'h40,1,26'h80,VA,0,0,0,     1,1,1,0,0,0,26'h1A0,26'h80,DA);
        add(0,1,26'h40,1,26'h80,VA,0,1,0,     1,0,1,0,0,0,26'h1A0,26'h80,DA);
        add(0,1,26'h40,1,26'h80,VA,0,0,0,     1,0,1,0,0,0,26'h1A0,26'h80,DA);
        add(0,1,26'h40,1,26'h80,VA,1,0,DB,    0,0,1,0,0,0,26'h1A0,26'h80,DA);
        add(0,1,26'h40,1,26'h80,VA,0,0,0,     0,0,1,1,0,0,26'h40,26'h80,DB);
        add(0,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,0,26'h40,26'h80,DB);
        add(0,1,26'h44,1,26'h84,VA,0,0,0,     1,1,1,0,0,0,26'h40,26'h84,DB);
        add(0,1,26'h44,1,26'h84,VA,1,0,DC,    0,0,1,0,0,1,26'h40,26'h84,DB);
        add(0,1,26'h44,1,26'h84,VA,0,0,0,     0,0,1,1,0,1,26'h44,26'h84,DC);
        add(0,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,1,26'h44,26'h84,DC);
        add(0,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,1,26'h44,26'h84,DC);
        add(1,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,0,26'h0,26'h0,0);
        add(0,1,26'h48,1,26'h88,VA,0,0,0,     1,1,1,0,0,0,26'h0,26'h88,0);
        add(0,1,26'h48,1,26'h88,VA,1,1,DD,    0,0,1,0,0,0,26'h0,26'h88,0);
        add(0,1,26'h48,1,26'h88,VA,0,0,0,     0,0,1,1,0,0,26'h48,26'h88,DD);
        add(0,0,26'h0,0,26'h0,0,0,0,0,        0,0,0,0,0,0,26'h48,26'h88,DD);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; miss_req = vecs[i].mreq; miss_addr = vecs[i].addr;
            victim_dirty = vecs[i].vd; victim_addr = vecs[i].vaddr;
            victim_data = vecs[i].vdata; read_ready_for_dcache = vecs[i].rdy;
            written_data_ack = vecs[i].ack; data_to_cache = vecs[i].din;
            tick();
            chk($sformatf("row%0d ctl", i),
                256'({reqD_cache, reqD_cache_write, busy, fill_valid,
                      err_timeout, err_wb_noack, fill_addr, reqAddrD_write_mem}),
                256'({vecs[i].e_req, vecs[i].e_wr, vecs[i].e_busy, vecs[i].e_fv,
                      vecs[i].e_eto, vecs[i].e_ewb, vecs[i].e_faddr, vecs[i].e_waddr}));
            chk($sformatf("row%0d fill_data", i), 256'(fill_data), 256'(vecs[i].e_fdata));
        end

        // Timeout: no ready for TIMEOUT WAIT cycles, miss_req held throughout.
        begin
            int hi = 0;
            int fv_seen = 0;
            do_reset();
            miss_req = 1; miss_addr = 26'h300; victim_dirty = 1;
            victim_addr = 26'h90; victim_data = VA;
            tick();
            chk("to accept req/addr", 256'({reqD_cache, reqD_cache_write, reqAddrD_mem}),
                256'({1'b1, 1'b1, 26'h300}));
            chk("to victim bus", 256'({reqAddrD_write_mem, data_from_cache}),
                256'({26'h90, VA}));
            for (int k = 0; k < 63; k++) begin
                tick();
                if (reqD_cache === 1'b1 && err_timeout === 1'b0) hi++;
                if (fill_valid !== 1'b0) fv_seen++;
            end
            chk("to req held 63", 256'(hi), 256'(63));
            tick();
            chk("to abort", 256'({err_timeout, reqD_cache, reqD_cache_write, busy, fill_valid}),
                256'(5'b10010));
            tick();
            if (fill_valid !== 1'b0) fv_seen++;
            chk("to busy falls", 256'({busy, reqD_cache, err_timeout}), 256'(3'b001));
            tick();
            chk("to next accepted", 256'({busy, reqD_cache, err_timeout}), 256'(3'b111));
            chk("to no fill", 256'(fv_seen), 256'(0));
        end

        // Back-to-back misses with miss_req held high.
        begin
            int fills = 0;
            int wcnt = 0;
            int lowrun = 0;
            int txn = 0;
            logic prev_req = 0;
            do_reset();
            miss_req = 1; miss_addr = 26'h100;
            for (int cyc = 0; cyc < 300 && fills < 3; cyc++) begin
                tick();
                if (fill_valid === 1'b1) begin
                    chk($sformatf("b2b fill%0d addr", fills), 256'(fill_addr),
                        256'(26'h100 + 26'(fills)));
                    fills++;
                    miss_addr = 26'h100 + 26'(fills);
                    if (fills == 3) miss_req = 0;
                end
                if (reqD_cache === 1'b1) begin
                    if (prev_req == 1'b0) begin
                        if (txn > 0) chk($sformatf("b2b gap%0d", txn), 256'(lowrun >= 1), 256'(1));
                        chk($sformatf("b2b req%0d addr", txn), 256'(reqAddrD_mem),
                            256'(26'h100 + 26'(txn)));
                        txn++;
                    end
                    lowrun = 0;
                    wcnt++;
                    read_ready_for_dcache = (wcnt == 3);
                    data_to_cache = {4{32'(txn)}};
                end else begin
                    lowrun++;
                    wcnt = 0;
                    read_ready_for_dcache = 0;
                end
                prev_req = reqD_cache;
            end
            chk("b2b fills", 256'(fills), 256'(3));
            chk("b2b txns", 256'(txn), 256'(3));
            read_ready_for_dcache = 0;
        end

        // Reset during WAIT, then a late ready from the controller.
        begin
            int fv_seen = 0;
            do_reset();
            miss_req = 1; miss_addr = 26'h200; victim_dirty = 1;
            victim_addr = 26'hA0; victim_data = VA;
            tick();
            tick();
            tick();
            chk("rst pre req", 256'(reqD_cache), 256'(1));
            reset = 1;
            tick();
            chk("rst outputs", 256'({reqD_cache, reqD_cache_write, busy, fill_valid,
                                     reqAddrD_mem, reqAddrD_write_mem}), 256'(0));
            chk("rst wdata", 256'(data_from_cache), 256'(0));
            reset = 0; miss_req = 0; victim_dirty = 0;
            read_ready_for_dcache = 1; written_data_ack = 1; data_to_cache = DD;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (fill_valid !== 1'b0 || reqD_cache !== 1'b0 || busy !== 1'b0) fv_seen++;
            end
            chk("rst late ready ignored", 256'(fv_seen), 256'(0));
            chk("rst errors clear", 256'({err_timeout, err_wb_noack}), 256'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
